mae_share_arb: RTL and testbench

//  Shares one MAE multiplier (18x18 -> 40b, fixed pipeline latency) between NREQ requesters.

---
 rtl/mae_arb_pkg.sv | 12 +
 rtl/mae_arb_rfifo.sv | 29 ++
 rtl/mae_share_arb.sv | 114 +++++++++++
 tb/tb_mae_share_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mae_arb_pkg.sv
// mae_arb_pkg: shared widths, in-flight tag record and flush FSM states for mae_share_arb
package mae_arb_pkg;
  localparam int MAE_AW = 18;
  localparam int MAE_PW = 40;
  localparam int MAE_IDW = 3;
  typedef struct packed {
    logic valid;
    logic [MAE_IDW-1:0] id;
    logic acc;
  } tag_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} fsm_t;
endpackage

// File: rtl/mae_arb_rfifo.sv
// mae_arb_rfifo: synchronous result FIFO with occupancy count; head reads as zero when empty
module mae_arb_rfifo #(
  parameter int DEPTH = 8,
  parameter int W = 42
) (
  input  logic clk,
  input  logic arst_n,
  input  logic wr_en,
  input  logic [W-1:0] wr_data,
  input  logic rd_en,
  output logic [W-1:0] rd_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wp[AW-1:0]] <= wr_data;
  assign count = wp - rp;
  assign rd_data = (count != '0) ? mem[rp[AW-1:0]] : '0;
endmodule

// File: rtl/mae_share_arb.sv
// mae_share_arb: round-robin sharing of one MAE multiplier with tagged, credit-protected results.
// Define MAE_ARB_ACCUM_EN to add the req_acc port and per-requester 40b accumulators.
module mae_share_arb
  import mae_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MAE_LAT = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic clk,
  input  logic arst_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [MAE_AW*NREQ-1:0] req_a,
  input  logic [MAE_AW*NREQ-1:0] req_b,
`ifdef MAE_ARB_ACCUM_EN
  input  logic [NREQ-1:0] req_acc,
`endif
  output logic [MAE_AW-1:0] mae_a,
  output logic [MAE_AW-1:0] mae_b,
  output logic mae_en,
  input  logic [MAE_PW-1:0] mae_p,
  output logic rsp_valid,
  input  logic rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [MAE_PW-1:0] rsp_p,
  input  logic flush,
  output logic flush_done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fsm_t state, state_nx;
  tag_t [MAE_LAT:0] tp;
  logic [IDW-1:0] rr, gnt_id, idx, wr_id;
  logic gnt_any, accept, pop, wr, acc_bit, unused;
  logic [CW-1:0] used, count;
  logic [MAE_PW-1:0] res;
  logic [IDW+MAE_PW-1:0] head;
  logic [MAE_AW-1:0] opa [NREQ];
  logic [MAE_AW-1:0] opb [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign opa[i] = req_a[MAE_AW*i +: MAE_AW];
    assign opb[i] = req_b[MAE_AW*i +: MAE_AW];
  end
  // scan farthest-first so the requester nearest after rr is the last (winning) assignment
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = rr;
    idx = rr;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(rr) + k) % NREQ);
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id = idx;
      end
    end
  end
  // used counts in-flight tags plus FIFO entries, so a granted op always has a FIFO slot
  assign accept = gnt_any && state == RUN && !flush && used < CW'(FIFO_DEPTH);
  assign req_ready = accept ? NREQ'(1) << gnt_id : '0;
  assign pop = rsp_valid && rsp_ready;
  assign wr = tp[MAE_LAT].valid;
  assign wr_id = tp[MAE_LAT].id[IDW-1:0];
  assign unused = ^{tp[MAE_LAT].acc, tp[MAE_LAT].id};
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state <= RUN;
      rr <= IDW'(NREQ - 1);
      used <= '0;
      mae_en <= 1'b0;
      mae_a <= '0;
      mae_b <= '0;
      tp <= '0;
    end else begin
      state <= state_nx;
      used <= used + CW'(accept) - CW'(pop);
      mae_en <= accept;
      tp[0] <= {accept, MAE_IDW'(gnt_id), acc_bit};
      for (int k = 1; k <= MAE_LAT; k++) tp[k] <= tp[k-1];
      if (accept) begin
        rr <= gnt_id;
        mae_a <= opa[gnt_id];
        mae_b <= opb[gnt_id];
      end
    end
  always_comb
    state_nx = state == RUN ? (flush ? DRAIN : RUN) : !flush ? RUN : used == '0 ? DONE : state;
  assign flush_done = state == DONE;
`ifdef MAE_ARB_ACCUM_EN
  logic [MAE_PW-1:0] acc [NREQ];
  assign acc_bit = req_acc[gnt_id];
  assign res = tp[MAE_LAT].acc ? acc[wr_id] + mae_p : mae_p;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      for (int i = 0; i < NREQ; i++) acc[i] <= '0;
    end else if (wr) begin
      acc[wr_id] <= res;
    end
`else
  assign acc_bit = 1'b0;
  assign res = mae_p;
`endif
  mae_arb_rfifo #(.DEPTH(FIFO_DEPTH), .W(IDW + MAE_PW)) u_fifo (
    .clk(clk),
    .arst_n(arst_n),
    .wr_en(wr),
    .wr_data({wr_id, res}),
    .rd_en(pop),
    .rd_data(head),
    .count(count)
  );
  assign rsp_valid = count != '0;
  assign {rsp_id, rsp_p} = head;
endmodule

// File: tb/tb_mae_share_arb.sv
// tb_mae_share_arb: directed tables and randomized traffic for mae_share_arb against a queue-based reference model
`timescale 1ns/1ps
module tb_mae_share_arb;
  localparam int NREQ = 4, LAT = 2, DEPTH = 8;
  logic clk = 0, arst_n = 0;
  logic [3:0] req_valid = '0, req_acc = '0, nxt_acc = '0, req_ready, smp_ready;
  logic [71:0] req_a = '0, req_b = '0;
  logic [17:0] mae_a, mae_b, prev_a, prev_b;
  logic mae_en, rsp_valid, flush_done, prev_acc, fl;
  logic rsp_ready = 0, flush = 0;
  logic [39:0] mae_p, p1, p2;
  logic [1:0] rsp_id;
  logic [39:0] rsp_p;
  int checks = 0, errors = 0;
  int m_rr, fs, cyc = 0, na, np;
  typedef struct {int id; logic [39:0] p; int due;} item_t;
  typedef struct {logic [3:0] v; logic [3:0] r;} vec_t;
  item_t q[$];
  logic [39:0] popped[$];
  logic [39:0] m_acc[4];
  vec_t fair[8] = '{'{4'hF, 4'h1}, '{4'hF, 4'h2}, '{4'hF, 4'h4}, '{4'hF, 4'h8},
                    '{4'hF, 4'h1}, '{4'hF, 4'h2}, '{4'hF, 4'h4}, '{4'hF, 4'h8}};

  always #5 clk = ~clk;

  mae_share_arb dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
`ifdef MAE_ARB_ACCUM_EN
    .req_acc(req_acc),
`endif
    .mae_a(mae_a), .mae_b(mae_b), .mae_en(mae_en), .mae_p(mae_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .flush(flush), .flush_done(flush_done)
  );

  function automatic logic [39:0] mul(input logic [17:0] a, input logic [17:0] b);
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return x[39:0];
  endfunction

  function automatic logic [71:0] rnd72();
    return 72'({$urandom, $urandom, $urandom});
  endfunction

  // two-stage MAE stand-in: product appears LAT cycles after the issue strobe
  always @(posedge clk) begin
    if (mae_en) p1 <= mul(mae_a, mae_b);
    p2 <= p1;
  end
  assign mae_p = p2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rr = NREQ - 1;
    fs = 0;
    prev_acc = 0;
    foreach (m_acc[i]) m_acc[i] = '0;
  endtask

  // one clock cycle: drive inputs at negedge, compare against the model, then advance the model
  task automatic step(input logic [3:0] v, input logic f, input logic rdy,
                      input logic [71:0] a, input logic [71:0] b);
    logic [3:0] er;
    logic rv;
    logic [39:0] p;
    int g;
    @(negedge clk);
    req_valid = v; flush = f; rsp_ready = rdy; req_a = a; req_b = b; req_acc = nxt_acc;
    #1;
    er = '0;
    g = 0;
    if (fs == 0 && !f && q.size() < DEPTH)
      for (int k = 1; k <= NREQ; k++)
        if (er == '0 && v[(m_rr + k) % NREQ]) begin
          g = (m_rr + k) % NREQ;
          er = 4'(1) << g;
        end
    rv = q.size() > 0 && q[0].due <= cyc;
    smp_ready = req_ready;
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, rv);
    chk("flush_done", flush_done, fs == 2);
    chk("mae_en", mae_en, prev_acc);
    if (prev_acc) chk("mae_ab", {mae_a, mae_b}, {prev_a, prev_b});
    fs = fs == 0 ? (f ? 1 : 0) : !f ? 0 : q.size() == 0 ? 2 : fs;
    if (rv && rdy) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_p", rsp_p, q[0].p);
      popped.push_back(rsp_p);
      void'(q.pop_front());
    end
    prev_acc = er != '0;
    if (prev_acc) begin
      prev_a = a[18*g +: 18];
      prev_b = b[18*g +: 18];
      p = mul(prev_a, prev_b);
`ifdef MAE_ARB_ACCUM_EN
      if (req_acc[g]) p = m_acc[g] + p;
      m_acc[g] = p;
`endif
      q.push_back('{g, p, cyc + LAT + 2});
      m_rr = g;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    req_valid = '0; flush = 0; rsp_ready = 0; arst_n = 0;
    #1;
    chk("reset_mae", {req_ready, mae_a, mae_b, mae_en}, '0);
    chk("reset_rsp", {rsp_valid, rsp_id, rsp_p, flush_done}, '0);
    model_reset();
    repeat (2) @(negedge clk);
    arst_n = 1;
  endtask

  initial begin
    model_reset();
    do_reset();
    step(4'b0001, 0, 0, 72'h3, 72'h3FFFB);
    repeat (3) step(4'b0000, 0, 0, '0, '0);
    chk("single_early", rsp_valid, 0);
    step(4'b0000, 0, 1, '0, '0);
    chk("single_valid", rsp_valid, 1);
    chk("single_id", rsp_id, 0);
    chk("single_p", rsp_p, 40'hFF_FFFF_FFF1);
    do_reset();
    foreach (fair[i]) begin
      step(fair[i].v, 0, 1, rnd72(), rnd72());
      chk("fair_grant", smp_ready, fair[i].r);
    end
    repeat (8) step(4'b0000, 0, 1, '0, '0);
    na = 0;
    repeat (12) begin
      step(4'b0001, 0, 0, rnd72(), rnd72());
      na += int'(smp_ready[0]);
    end
    chk("bp_accepts", na, 8);
    step(4'b0001, 0, 1, rnd72(), rnd72());
    chk("bp_full", smp_ready, 0);
    na = 0;
    repeat (3) begin
      step(4'b0001, 0, 0, rnd72(), rnd72());
      na += int'(smp_ready[0]);
    end
    chk("bp_one_more", na, 1);
    repeat (14) step(4'b0000, 0, 1, '0, '0);
    chk("bp_drained", rsp_valid, 0);
    repeat (3) step(4'b0111, 0, 0, rnd72(), rnd72());
    na = 0;
    np = 0;
    for (int i = 0; i < 10; i++) begin
      step(4'hF, 1, 1, rnd72(), rnd72());
      na += int'(smp_ready != '0);
      np += int'(rsp_valid);
    end
    chk("flush_grants", na, 0);
    chk("flush_pops", np, 3);
    chk("flush_done_hi", flush_done, 1);
    step(4'hF, 0, 1, rnd72(), rnd72());
    chk("flush_release", smp_ready, 0);
    step(4'hF, 0, 1, rnd72(), rnd72());
    chk("flush_resume", smp_ready != '0, 1);
    repeat (2) step(4'b0010, 0, 0, rnd72(), rnd72());
    do_reset();
    repeat (6) step(4'b0000, 0, 1, '0, '0);
    chk("reset_no_stale", rsp_valid, 0);
`ifdef MAE_ARB_ACCUM_EN
    do_reset();
    popped.delete();
    nxt_acc = 4'b0000;
    step(4'b0010, 0, 1, {36'd0, 18'd2, 18'd0}, {36'd0, 18'd3, 18'd0});
    nxt_acc = 4'b0010;
    step(4'b0010, 0, 1, {36'd0, 18'd4, 18'd0}, {36'd0, 18'd5, 18'd0});
    step(4'b0010, 0, 1, {36'd0, 18'h3FFFF, 18'd0}, {36'd0, 18'd1, 18'd0});
    nxt_acc = 4'b0000;
    repeat (8) step(4'b0000, 0, 1, '0, '0);
    chk("acc_count", popped.size(), 3);
    chk("acc_0", popped[0], 40'd6);
    chk("acc_1", popped[1], 40'd26);
    chk("acc_2", popped[2], 40'd25);
`endif
    fl = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) fl = !fl;
      nxt_acc = 4'($urandom);
      step(4'($urandom), fl, $urandom_range(0, 3) != 0, rnd72(), rnd72());
    end
    nxt_acc = '0;
    repeat (16) step(4'b0000, 0, 1, '0, '0);
    chk("final_empty", rsp_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
